// File: rtl/dsp_be_mlse_dec_array.sv
// dsp_be_mlse_dec_array: registered MLSE decision array resolving all PRLL_RANK interleaved lanes of a beat per clock
// Ports: i_clk; i_rst asynchronous active-high reset; i_clr synchronous clear; i_vld beat valid; i_bypass slicer passthrough;
//   i_flag_unit 8 bits per lane {p1a,p1b,p2,p3a,p3b,p3o,p4m,p4p}, lane 0 (oldest) in the LSBs;
//   i_ari_unit 3 bits per lane {dpre,dpst,dcomp}, lane 0 in the LSBs;
//   o_vld output valid; o_drx decided bits (bit k = lane k);
//   o_hit_cnt saturating pattern-hit counter, present only when DSP_BE_MLSE_DEC_HIT_CNT_EN is defined.
module dsp_be_mlse_dec_array #(
    parameter int PRLL_RANK = 16,
    parameter int CntWidth = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_vld,
    input  logic                   i_bypass,
    input  logic [PRLL_RANK*8-1:0] i_flag_unit,
    input  logic [PRLL_RANK*3-1:0] i_ari_unit,
    output logic                   o_vld,
`ifdef DSP_BE_MLSE_DEC_HIT_CNT_EN
    output logic [CntWidth-1:0]    o_hit_cnt,
`endif
    output logic [PRLL_RANK-1:0]   o_drx
);
    if (PRLL_RANK < 3 || CntWidth < 1) begin : g_bad_param
        $error("dsp_be_mlse_dec_array: PRLL_RANK must be >= 3 and CntWidth >= 1");
    end
    logic [15:0]                  hist_f;
    logic [5:0]                   hist_a;
    logic [(PRLL_RANK+2)*8-1:0]   ext_f;
    logic [(PRLL_RANK+2)*3-1:0]   ext_a;
    logic [PRLL_RANK-1:0]         dec;
    // Extended views: entries 0,1 are the last two lanes of the previous valid beat.
    assign ext_f = {i_flag_unit, hist_f};
    assign ext_a = {i_ari_unit, hist_a};
    for (genvar k = 0; k < PRLL_RANK; k++) begin : g_lane
        logic [7:0] d0, dm1, dm2;
        logic [2:0] a;
        assign d0  = ext_f[(k+2)*8 +: 8];
        assign dm1 = ext_f[(k+1)*8 +: 8];
        assign dm2 = ext_f[k*8 +: 8];
        assign a   = ext_a[k*3 +: 3];
        assign dec[k] = i_bypass ? a[1] :
                        d0[3]    ? ~a[2] :
                        d0[5]    ? a[1] :
                        dm1[7]   ? a[1] :
                        dm1[6]   ? a[2] :
                        dm1[2]   ? a[0] :
                        dm1[5]   ? ~a[2] :
                        dm1[1]   ? 1'b0 :
                        dm1[0]   ? 1'b1 :
                        dm2[4]   ? ~a[1] :
                        dm2[5]   ? a[2] : a[1];
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_vld  <= 1'b0;
            o_drx  <= '0;
            hist_f <= '0;
            hist_a <= '0;
        end else if (i_clr) begin
            o_vld  <= 1'b0;
            o_drx  <= '0;
            hist_f <= '0;
            hist_a <= '0;
        end else begin
            o_vld <= i_vld;
            if (i_vld) begin
                o_drx  <= dec;
                hist_f <= i_flag_unit[PRLL_RANK*8-1 -: 16];
                hist_a <= i_ari_unit[PRLL_RANK*3-1 -: 6];
            end
        end
    end
`ifdef DSP_BE_MLSE_DEC_HIT_CNT_EN
    localparam int HW = $clog2(PRLL_RANK + 1);
    localparam int SW = CntWidth + HW + 1;
    logic [PRLL_RANK-1:0] hit;
    logic [HW-1:0]        n_hit;
    logic [SW-1:0]        sum;
    // A hit is any of the ten pattern rules firing; bypass suppresses all hits.
    for (genvar k = 0; k < PRLL_RANK; k++) begin : g_hit
        assign hit[k] = ~i_bypass & (g_lane[k].d0[3] | g_lane[k].d0[5] |
                        g_lane[k].dm1[7] | g_lane[k].dm1[6] | g_lane[k].dm1[5] | g_lane[k].dm1[2] |
                        g_lane[k].dm1[1] | g_lane[k].dm1[0] | g_lane[k].dm2[4] | g_lane[k].dm2[5]);
    end
    always_comb begin
        n_hit = '0;
        for (int k = 0; k < PRLL_RANK; k++) n_hit = n_hit + HW'(hit[k]);
        sum = SW'(o_hit_cnt) + SW'(n_hit);
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_hit_cnt <= '0;
        else if (i_clr) o_hit_cnt <= '0;
        else if (i_vld) o_hit_cnt <= (sum > SW'({CntWidth{1'b1}})) ? '1 : sum[CntWidth-1:0];
    end
`endif
endmodule

// File: tb/tb_dsp_be_mlse_dec_array.sv
// tb_dsp_be_mlse_dec_array: directed bench with a behavioural rule-table model and per-cycle output comparison
module tb_dsp_be_mlse_dec_array;
    localparam int N = 16;
    localparam int CW = 4;
    localparam int P1A = 7, P1B = 6, P2 = 5, P3A = 4, P3B = 3, P3O = 2, P4M = 1, P4P = 0;
    localparam int DPRE = 2, DPST = 1, DCOMP = 0;

    logic clk = 0, rst = 1, clr = 0, vld = 0, byp = 0, go = 0;
    logic [7:0] fl [N];
    logic [2:0] ar [N];
    logic [N*8-1:0] flag_bus;
    logic [N*3-1:0] ari_bus;
    logic o_vld;
    logic [N-1:0] o_drx;
    logic [CW-1:0] o_hit_cnt;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        flag_bus = '0;
        ari_bus = '0;
        for (int k = 0; k < N; k++) begin
            flag_bus[k*8 +: 8] = fl[k];
            ari_bus[k*3 +: 3] = ar[k];
        end
    end

    dsp_be_mlse_dec_array #(.PRLL_RANK(N), .CntWidth(CW)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_clr(clr),
        .i_vld(vld),
        .i_bypass(byp),
        .i_flag_unit(flag_bus),
        .i_ari_unit(ari_bus),
        .o_vld(o_vld),
`ifdef DSP_BE_MLSE_DEC_HIT_CNT_EN
        .o_hit_cnt(o_hit_cnt),
`endif
        .o_drx(o_drx)
    );
`ifndef DSP_BE_MLSE_DEC_HIT_CNT_EN
    assign o_hit_cnt = '0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: previous valid beat kept whole; each lane walks the ordered rule table.
    logic [7:0] pf [N];
    logic [2:0] pa [N];
    logic [7:0] ef [N+2];
    logic [2:0] ea [N+2];
    logic [7:0] d0, d1, d2;
    logic [2:0] a;
    bit c [10];
    bit v [10];
    bit r, h;
    int nh;
    logic exp_vld = 0;
    logic [N-1:0] exp_drx = '0;
    int exp_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            exp_vld = 0;
            exp_drx = '0;
            exp_cnt = 0;
            for (int k = 0; k < N; k++) begin
                pf[k] = '0;
                pa[k] = '0;
            end
        end else begin
            exp_vld = vld;
            if (vld) begin
                for (int j = 0; j < N + 2; j++) begin
                    ef[j] = (j < 2) ? pf[N-2+j] : fl[j-2];
                    ea[j] = (j < 2) ? pa[N-2+j] : ar[j-2];
                end
                nh = 0;
                for (int k = 0; k < N; k++) begin
                    d0 = ef[k+2];
                    d1 = ef[k+1];
                    d2 = ef[k];
                    a = ea[k];
                    c = '{d0[P3B], d0[P2], d1[P1A], d1[P1B], d1[P3O], d1[P2], d1[P4M], d1[P4P], d2[P3A], d2[P2]};
                    v = '{~a[DPRE], a[DPST], a[DPST], a[DPRE], a[DCOMP], ~a[DPRE], 1'b0, 1'b1, ~a[DPST], a[DPRE]};
                    r = a[DPST];
                    h = 0;
                    for (int i = 9; i >= 0; i--) if (c[i]) begin
                        r = v[i];
                        h = 1;
                    end
                    if (byp) begin
                        r = a[DPST];
                        h = 0;
                    end
                    exp_drx[k] = r;
                    nh += int'(h);
                end
                exp_cnt = (exp_cnt + nh > 2**CW - 1) ? 2**CW - 1 : exp_cnt + nh;
                for (int k = 0; k < N; k++) begin
                    pf[k] = fl[k];
                    pa[k] = ar[k];
                end
            end
        end
    end

    always @(negedge clk) if (go) begin
        chk("model_vld", 32'(o_vld), 32'(exp_vld));
        chk("model_drx", 32'(o_drx), 32'(exp_drx));
`ifdef DSP_BE_MLSE_DEC_HIT_CNT_EN
        chk("model_cnt", 32'(o_hit_cnt), 32'(exp_cnt));
`endif
    end

    task automatic zero_in();
        for (int k = 0; k < N; k++) begin
            fl[k] = '0;
            ar[k] = '0;
        end
    endtask

    task automatic rand_in();
        for (int k = 0; k < N; k++) begin
            fl[k] = 8'($urandom);
            ar[k] = 3'($urandom);
        end
    endtask

    logic [CW-1:0] cnt_hold;

    initial begin
        zero_in();
        repeat (2) @(negedge clk);
        chk("reset_vld", 32'(o_vld), 0);
        chk("reset_drx", 32'(o_drx), 0);
        chk("reset_cnt", 32'(o_hit_cnt), 0);
        rst = 0;
        go = 1;
        // zero history makes lanes 0/1 default to 0 on the first beat
        for (int k = 0; k < N; k++) ar[k] = 3'b010;
        vld = 1;
        @(negedge clk);
        chk("t1_vld", 32'(o_vld), 1);
        chk("t1_first", 32'(o_drx), 32'h0000_FFFC);
        @(negedge clk);
        chk("t1_second", 32'(o_drx), 32'h0000_FFFF);
        // rule 1 outranks rule 8, then rule 8 alone
        zero_in();
        fl[5][P3B] = 1;
        fl[4][P4P] = 1;
        ar[3][DPRE] = 1;
        @(negedge clk);
        chk("t2_p3b", 32'(o_drx[5]), 0);
        fl[5][P3B] = 0;
        @(negedge clk);
        chk("t2_p4p", 32'(o_drx[5]), 1);
        // cross-beat rule 4 through history, back to back then with a gap
        zero_in();
        fl[N-1][P1B] = 1;
        ar[N-2][DPRE] = 1;
        @(negedge clk);
        zero_in();
        @(negedge clk);
        chk("t3_cross", 32'(o_drx[0]), 1);
        fl[N-1][P1B] = 1;
        ar[N-2][DPRE] = 1;
        @(negedge clk);
        vld = 0;
        zero_in();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_gap_vld", 32'(o_vld), 0);
        end
        vld = 1;
        @(negedge clk);
        chk("t3_gap_cross", 32'(o_drx[0]), 1);
        // bypass with random flags
        cnt_hold = o_hit_cnt;
        byp = 1;
        for (int i = 0; i < 6; i++) begin
            rand_in();
            @(negedge clk);
        end
        chk("t4_cnt_hold", 32'(o_hit_cnt), 32'(cnt_hold));
        byp = 0;
        // clear with a valid beat drops that beat
        rand_in();
        clr = 1;
        @(negedge clk);
        chk("t5_clr_vld", 32'(o_vld), 0);
        chk("t5_clr_drx", 32'(o_drx), 0);
        clr = 0;
        zero_in();
        for (int k = 0; k < N; k++) ar[k] = 3'b010;
        @(negedge clk);
        chk("t5_after_clr", 32'(o_drx), 32'h0000_FFFC);
        // non-bypass random beats
        for (int i = 0; i < 8; i++) begin
            rand_in();
            @(negedge clk);
        end
`ifdef DSP_BE_MLSE_DEC_HIT_CNT_EN
        clr = 1;
        @(negedge clk);
        clr = 0;
        zero_in();
        fl[3][P3B] = 1;
        fl[8][P3B] = 1;
        fl[13][P3B] = 1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("t6_cnt", 32'(o_hit_cnt), (3 * i > 15) ? 15 : 3 * i);
        end
        clr = 1;
        @(negedge clk);
        chk("t6_cnt_clr", 32'(o_hit_cnt), 0);
        clr = 0;
`endif
        // asynchronous reset in the middle of a beat
        rand_in();
        vld = 1;
        @(posedge clk);
        #1 rst = 1;
        #2;
        chk("rst_mid_vld", 32'(o_vld), 0);
        chk("rst_mid_drx", 32'(o_drx), 0);
        vld = 0;
        rst = 0;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
